// File: rtl/weight_tile_fifo.sv
// weight_tile_fifo: buffers whole weight tiles between the weight loader and the PE array.
// Latency: a committed tile is readable the cycle after its last row beat is accepted.
// Backpressure: wr_ready drops while all slots are committed; rd_valid only for whole tiles.
//
// Ports:
//   clk, rstn       clock, asynchronous active-low reset
//   flush           synchronous clear (present only with WEIGHT_TILE_FIFO_FLUSH_EN defined)
//   wr_valid/ready  row-beat handshake; wr_row_data is one PE row, wr_row_idx is the row it fills
//   rd_valid/ready  whole-tile handshake; rd_data is the head tile (zeros when empty)
//   count           committed tiles held; almost_full = count >= AF_THRESH
//
// Optional feature macro: WEIGHT_TILE_FIFO_FLUSH_EN (adds the flush input).
module weight_tile_fifo #(
  parameter int WEIGHT_BW   = 8,
  parameter int NUM_PE_ROWS = 8,
  parameter int MATRIX_SIZE = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int AF_THRESH   = FIFO_DEPTH - 1
) (
  input  logic                                         clk,
  input  logic                                         rstn,
`ifdef WEIGHT_TILE_FIFO_FLUSH_EN
  input  logic                                         flush,
`endif
  input  logic                                         wr_valid,
  output logic                                         wr_ready,
  input  logic [WEIGHT_BW*MATRIX_SIZE-1:0]             wr_row_data,
  output logic [$clog2(NUM_PE_ROWS)-1:0]               wr_row_idx,
  output logic                                         rd_valid,
  input  logic                                         rd_ready,
  output logic [WEIGHT_BW*NUM_PE_ROWS*MATRIX_SIZE-1:0] rd_data,
  output logic [$clog2(FIFO_DEPTH):0]                  count,
  output logic                                         almost_full
);

  localparam int ROW_W = WEIGHT_BW * MATRIX_SIZE;
  localparam int RIW   = $clog2(NUM_PE_ROWS);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;

  localparam logic [RIW-1:0] LAST_ROW = RIW'(NUM_PE_ROWS - 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]  AF_CNT   = CW'(AF_THRESH);

  // Each slot is a packed array of rows so a beat writes exactly one row,
  // and the flattened slot already has row r at bits [r*ROW_W +: ROW_W].
  logic [NUM_PE_ROWS-1:0][ROW_W-1:0] mem [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          flush_i;
  logic          wr_fire;
  logic          commit;
  logic          pop;

`ifdef WEIGHT_TILE_FIFO_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Status depends on count alone, so no input-to-output combinational path exists.
  assign wr_ready    = (count < FULL_CNT);
  assign rd_valid    = (count != '0);
  assign almost_full = (count >= AF_CNT);

  assign wr_fire = wr_valid && wr_ready;
  assign commit  = wr_fire && (wr_row_idx == LAST_ROW);
  assign pop     = rd_valid && rd_ready;

  // Only committed slots are ever shown; the slot being assembled is never rd_ptr
  // while count is nonzero... unless full, in which case no beat is accepted.
  assign rd_data = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      wr_row_idx <= '0;
    end else if (flush_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      wr_row_idx <= '0;
    end else begin
      if (wr_fire) begin
        wr_row_idx <= commit ? '0 : wr_row_idx + 1'b1;
      end
      if (commit) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Single counter: simultaneous commit and pop cancel out.
      case ({commit, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; stale contents are unreachable through count.
  always_ff @(posedge clk) begin
    if (wr_fire && !flush_i) begin
      mem[wr_ptr][wr_row_idx] <= wr_row_data;
    end
  end

endmodule

// File: tb/tb_weight_tile_fifo.sv
// Randomised and directed bench for weight_tile_fifo against a queue-of-tiles model.
module tb_weight_tile_fifo;

  localparam int WBW    = 8;
  localparam int NR     = 8;
  localparam int MS     = 8;
  localparam int DEPTH  = 4;
  localparam int AF     = DEPTH - 1;
  localparam int ROW_W  = WBW * MS;
  localparam int TILE_W = ROW_W * NR;
  localparam int RIW    = $clog2(NR);
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [ROW_W-1:0]  wr_row_data = '0;
  logic [RIW-1:0]    wr_row_idx;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [TILE_W-1:0] rd_data;
  logic [CW-1:0]     count;
  logic              almost_full;
`ifdef WEIGHT_TILE_FIFO_FLUSH_EN
  logic              flush = 1'b0;
`endif

  weight_tile_fifo #(
    .WEIGHT_BW(WBW), .NUM_PE_ROWS(NR), .MATRIX_SIZE(MS),
    .FIFO_DEPTH(DEPTH), .AF_THRESH(AF)
  ) dut (
    .clk(clk),
    .rstn(rstn),
`ifdef WEIGHT_TILE_FIFO_FLUSH_EN
    .flush(flush),
`endif
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_row_data(wr_row_data),
    .wr_row_idx(wr_row_idx),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_data(rd_data),
    .count(count),
    .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: committed tiles in a queue, plus the tile under assembly.
  logic [TILE_W-1:0] q[$];
  logic [TILE_W-1:0] part;
  int                part_rows;

  task automatic check(input string tag, input logic [TILE_W-1:0] got, input logic [TILE_W-1:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic check_outputs();
    logic [TILE_W-1:0] head;
    head = (q.size() != 0) ? q[0] : '0;
    check("wr_ready", TILE_W'(wr_ready), TILE_W'(q.size() < DEPTH));
    check("wr_row_idx", TILE_W'(wr_row_idx), TILE_W'(part_rows));
    check("rd_valid", TILE_W'(rd_valid), TILE_W'(q.size() != 0));
    check("rd_data", rd_data, head);
    check("count", TILE_W'(count), TILE_W'(q.size()));
    check("almost_full", TILE_W'(almost_full), TILE_W'(q.size() >= AF));
  endtask

  task automatic model_reset();
    q.delete();
    part      = '0;
    part_rows = 0;
  endtask

  // One clock: check at the falling edge, drive, then apply the model's rules at the rising edge.
  task automatic cycle(input logic wv, input logic [ROW_W-1:0] d, input logic rr, input logic fl);
    bit acc, pp;
    @(negedge clk);
    check_outputs();
    wr_valid    = wv;
    wr_row_data = d;
    rd_ready    = rr;
`ifdef WEIGHT_TILE_FIFO_FLUSH_EN
    flush       = fl;
`endif
    @(posedge clk);
    if (fl) begin
      model_reset();
    end else begin
      acc = wv && (q.size() < DEPTH);
      pp  = rr && (q.size() != 0);
      if (pp) void'(q.pop_front());
      if (acc) begin
        part[part_rows*ROW_W +: ROW_W] = d;
        part_rows++;
        if (part_rows == NR) begin
          q.push_back(part);
          part_rows = 0;
        end
      end
    end
  endtask

  function automatic logic [ROW_W-1:0] pat(input int t, input int r);
    logic [7:0] b;
    b = 8'((t << 3) + r + 1);
    return {b, 8'hA5, b, 8'(t), b, 8'(r), b, ~b};
  endfunction

  task automatic push_tile(input int t, input logic rr);
    for (int r = 0; r < NR; r++) cycle(1'b1, pat(t, r), rr, 1'b0);
  endtask

  logic [TILE_W-1:0] exp_tile;

  initial begin
    model_reset();

    // Reset state
    #12;
    check_outputs();
    @(negedge clk);
    rstn = 1'b1;

    // Fill one tile with row r = {8{r+1}}
    for (int r = 0; r < NR; r++) cycle(1'b1, {8{8'(r + 1)}}, 1'b0, 1'b0);
    #1;
    check("fill_row7", TILE_W'(rd_data[7*ROW_W +: ROW_W]), TILE_W'(64'h0808080808080808));
    check("fill_count", TILE_W'(count), TILE_W'(1));

    // Full
    for (int t = 1; t < DEPTH; t++) push_tile(t, 1'b0);
    #1;
    check("full_count", TILE_W'(count), TILE_W'(DEPTH));
    check("full_wr_ready", TILE_W'(wr_ready), TILE_W'(0));
    check("full_af", TILE_W'(almost_full), TILE_W'(1));
    cycle(1'b1, pat(9, 0), 1'b0, 1'b0);
    cycle(1'b1, pat(9, 1), 1'b0, 1'b0);
    #1;
    check("full_idx_held", TILE_W'(wr_row_idx), TILE_W'(0));

    // Pop at full, then last beat coinciding with a pop
    cycle(1'b0, '0, 1'b1, 1'b0);
    #1;
    check("pop_full_wr_ready", TILE_W'(wr_ready), TILE_W'(1));
    for (int r = 0; r < NR - 1; r++) cycle(1'b1, pat(20, r), 1'b0, 1'b0);
    cycle(1'b1, pat(20, NR - 1), 1'b1, 1'b0);
    #1;
    check("commit_pop_count", TILE_W'(count), TILE_W'(3));
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Wrap: 10 tiles streamed through with the consumer always ready
    for (int t = 0; t < 10; t++) push_tile(30 + t, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    #1;
    check("wrap_rd_valid", TILE_W'(rd_valid), TILE_W'(0));

    // Reset mid-tile
    push_tile(50, 1'b0);
    for (int r = 0; r < 3; r++) cycle(1'b1, pat(51, r), 1'b0, 1'b0);
    @(negedge clk);
    wr_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check("rst_wr_ready", TILE_W'(wr_ready), TILE_W'(1));
    check("rst_idx", TILE_W'(wr_row_idx), TILE_W'(0));
    check("rst_rd_valid", TILE_W'(rd_valid), TILE_W'(0));
    check("rst_rd_data", rd_data, '0);
    check("rst_count", TILE_W'(count), TILE_W'(0));
    check("rst_af", TILE_W'(almost_full), TILE_W'(0));
    @(negedge clk);
    rstn = 1'b1;
    push_tile(60, 1'b0);
    #1;
    for (int r = 0; r < NR; r++) exp_tile[r*ROW_W +: ROW_W] = pat(60, r);
    check("post_rst_count", TILE_W'(count), TILE_W'(1));
    check("post_rst_data", rd_data, exp_tile);

`ifdef WEIGHT_TILE_FIFO_FLUSH_EN
    // Flush with count=2, a partial tile, a beat and a pop all in the same cycle
    push_tile(61, 1'b0);
    for (int r = 0; r < 3; r++) cycle(1'b1, pat(62, r), 1'b0, 1'b0);
    cycle(1'b1, pat(62, 3), 1'b1, 1'b1);
    #1;
    check("flush_count", TILE_W'(count), TILE_W'(0));
    check("flush_rd_valid", TILE_W'(rd_valid), TILE_W'(0));
    check("flush_idx", TILE_W'(wr_row_idx), TILE_W'(0));
`endif

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), {$urandom, $urandom},
            1'($urandom_range(0, 2) == 0), 1'b0);
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
